// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults for the scoreboarded register file.
//   XLEN_DEFAULT   - default data width in bits
//   NREG_DEFAULT   - default register count (power of two, >= 2)
//   ADDR_W_DEFAULT - register address width for the default register count
//   ZERO_REG       - index of the hardwired zero register
package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT   = 32;
    localparam int unsigned NREG_DEFAULT   = 32;
    localparam int unsigned ADDR_W_DEFAULT = $clog2(NREG_DEFAULT);
    localparam int unsigned ZERO_REG       = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one pending bit per register, marking an outstanding write.
// Ports:
//   clk_i              clock, state updates on rising edge
//   reset_i            synchronous active-high reset, clears every pending bit
//   set_i, set_addr_i  issue: mark set_addr_i pending
//   clr_i, clr_addr_i  write-back: clear clr_addr_i
//   rd_addr1_i/2_i     lookup addresses
//   pend1_o/2_o        stored pending bit at each lookup address
// The zero register is never pending. When set and clear hit the same register in
// one cycle, set wins: the newly issued instruction is the outstanding producer.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int unsigned NREG   = NREG_DEFAULT,
    localparam int unsigned ADDR_W = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] rd_addr1_i,
    input  logic [ADDR_W-1:0] rd_addr2_i,
    output logic              pend1_o,
    output logic              pend2_o
);

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        // Clear first so a same-cycle set overrides it.
        if (clr_i && (clr_addr_i != ADDR_W'(ZERO_REG))) begin
            pending_d[clr_addr_i] = 1'b0;
        end
        if (set_i && (set_addr_i != ADDR_W'(ZERO_REG))) begin
            pending_d[set_addr_i] = 1'b1;
        end
        pending_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pend1_o = pending_q[rd_addr1_i];
    assign pend2_o = pending_q[rd_addr2_i];

endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: NREG x XLEN register file, one write port, two bypassed
// combinational read ports, hardwired zero register, per-register pending scoreboard.
// Ports:
//   clk, reset (sync, active-high)
//   Read_register1/2 -> Read_data1/2, Read_pending1/2   combinational reads
//   RegWrite, Write_register, Write_data                 write-back port
//   Issue, Issue_register                                marks destination pending
// A read of the register being written this cycle returns Write_data with pending 0,
// so decode sees the value it would otherwise have to wait one cycle for.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN   = XLEN_DEFAULT,
    parameter  int unsigned NREG   = NREG_DEFAULT,
    localparam int unsigned ADDR_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Read_register1,
    input  logic [ADDR_W-1:0] Read_register2,
    output logic [XLEN-1:0]   Read_data1,
    output logic [XLEN-1:0]   Read_data2,
    output logic              Read_pending1,
    output logic              Read_pending2,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] Write_register,
    input  logic [XLEN-1:0]   Write_data,
    input  logic              Issue,
    input  logic [ADDR_W-1:0] Issue_register
);

    logic [XLEN-1:0] regs_q [NREG];
    logic            sb_pend1;
    logic            sb_pend2;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (RegWrite && (Write_register != ADDR_W'(ZERO_REG))) begin
            regs_q[Write_register] <= Write_data;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk_i      (clk),
        .reset_i    (reset),
        .set_i      (Issue),
        .set_addr_i (Issue_register),
        .clr_i      (RegWrite),
        .clr_addr_i (Write_register),
        .rd_addr1_i (Read_register1),
        .rd_addr2_i (Read_register2),
        .pend1_o    (sb_pend1),
        .pend2_o    (sb_pend2)
    );

    function automatic logic [XLEN-1:0] read_data(
        input logic [ADDR_W-1:0] addr,
        input logic [XLEN-1:0]   stored
    );
        if (addr == ADDR_W'(ZERO_REG)) begin
            return '0;
        end else if (RegWrite && (Write_register == addr)) begin
            return Write_data;
        end
        return stored;
    endfunction

    // Pending is masked while the producing write is being bypassed.
    function automatic logic read_pend(
        input logic [ADDR_W-1:0] addr,
        input logic              stored
    );
        if (addr == ADDR_W'(ZERO_REG)) begin
            return 1'b0;
        end else if (RegWrite && (Write_register == addr)) begin
            return 1'b0;
        end
        return stored;
    endfunction

    always_comb begin
        Read_data1    = read_data(Read_register1, regs_q[Read_register1]);
        Read_data2    = read_data(Read_register2, regs_q[Read_register2]);
        Read_pending1 = read_pend(Read_register1, sb_pend1);
        Read_pending2 = read_pend(Read_register2, sb_pend2);
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: stimulus drives one cycle of inputs just after each
// rising edge and queues the expected read-port outputs; a monitor on the falling
// edge pops each expectation and compares it against the DUT.
module tb_register_file_sb;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned ADDR_W = $clog2(NREG);

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] Read_register1;
    logic [ADDR_W-1:0] Read_register2;
    logic [XLEN-1:0]   Read_data1;
    logic [XLEN-1:0]   Read_data2;
    logic              Read_pending1;
    logic              Read_pending2;
    logic              RegWrite;
    logic [ADDR_W-1:0] Write_register;
    logic [XLEN-1:0]   Write_data;
    logic              Issue;
    logic [ADDR_W-1:0] Issue_register;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string           name;
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d2;
        logic            p1;
        logic            p2;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    register_file_sb #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .Read_register1 (Read_register1),
        .Read_register2 (Read_register2),
        .Read_data1     (Read_data1),
        .Read_data2     (Read_data2),
        .Read_pending1  (Read_pending1),
        .Read_pending2  (Read_pending2),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_data     (Write_data),
        .Issue          (Issue),
        .Issue_register (Issue_register)
    );

    // Monitor: outputs are stable by the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks += 4;
            if (Read_data1 !== e.d1) begin
                n_fail++;
                $display("FAIL %s data1: got %h want %h", e.name, Read_data1, e.d1);
            end
            if (Read_data2 !== e.d2) begin
                n_fail++;
                $display("FAIL %s data2: got %h want %h", e.name, Read_data2, e.d2);
            end
            if (Read_pending1 !== e.p1) begin
                n_fail++;
                $display("FAIL %s pend1: got %b want %b", e.name, Read_pending1, e.p1);
            end
            if (Read_pending2 !== e.p2) begin
                n_fail++;
                $display("FAIL %s pend2: got %b want %b", e.name, Read_pending2, e.p2);
            end
        end
    end

    task automatic cyc(
        input string             name,
        input logic              rst,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [XLEN-1:0]   wd,
        input logic              iss,
        input logic [ADDR_W-1:0] ia,
        input logic [ADDR_W-1:0] r1,
        input logic [ADDR_W-1:0] r2,
        input logic [XLEN-1:0]   e1,
        input logic [XLEN-1:0]   e2,
        input logic              ep1,
        input logic              ep2
    );
        exp_t e;
        @(posedge clk);
        #1;
        reset          = rst;
        RegWrite       = we;
        Write_register = wa;
        Write_data     = wd;
        Issue          = iss;
        Issue_register = ia;
        Read_register1 = r1;
        Read_register2 = r2;
        e.name = name;
        e.d1   = e1;
        e.d2   = e2;
        e.p1   = ep1;
        e.p2   = ep2;
        exp_q.push_back(e);
    endtask

    initial begin
        reset          = 1'b1;
        RegWrite       = 1'b0;
        Write_register = '0;
        Write_data     = '0;
        Issue          = 1'b0;
        Issue_register = '0;
        Read_register1 = '0;
        Read_register2 = '0;

        // Reset held for two edges; reads inside reset are already zero.
        cyc("rst_a", 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        cyc("rst_b", 1, 0, 0, 0, 0, 0, 31, 7, 0, 0, 0, 0);
        for (int a = 0; a < int'(NREG); a++) begin
            cyc("post_rst", 0, 0, 0, 0, 0, 0, ADDR_W'(a), ADDR_W'(NREG - 1 - a), 0, 0, 0, 0);
        end

        // r5 write, bypassed in the write cycle, stored afterwards; r0 ignores writes.
        cyc("wr5_byp", 0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        cyc("rd5",     0, 0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        cyc("wr0",     0, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("rd0_5",   0, 0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0);

        // r10 bypass on port 1 only; then independent ports.
        cyc("wr10_byp", 0, 1, 10, 32'hA5A5A5A5, 0, 0, 10, 11, 32'hA5A5A5A5, 0, 0, 0);
        cyc("rd10_5",   0, 0, 0, 0, 0, 0, 10, 5, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 0);

        // Issue r15, pending next cycle, cleared by write (bypass) and after the edge.
        cyc("iss15",     0, 0, 0, 0, 1, 15, 15, 15, 0, 0, 0, 0);
        cyc("pend15",    0, 0, 0, 0, 0, 0, 15, 15, 0, 0, 1, 1);
        cyc("wr15_byp",  0, 1, 15, 32'd7, 0, 0, 15, 15, 32'd7, 32'd7, 0, 0);
        cyc("rd15",      0, 0, 0, 0, 0, 0, 15, 15, 32'd7, 32'd7, 0, 0);

        // Same-cycle issue+write to r20: new producer wins, pending ends set.
        cyc("iss_wr20",  0, 1, 20, 32'h55, 1, 20, 20, 20, 32'h55, 32'h55, 0, 0);
        cyc("pend20",    0, 0, 0, 0, 0, 0, 20, 20, 32'h55, 32'h55, 1, 1);
        cyc("iss0",      0, 0, 0, 0, 1, 0, 0, 20, 0, 32'h55, 0, 1);
        cyc("rd0_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Re-issue of a pending register does not count; one write clears it.
        cyc("reiss20",   0, 0, 0, 0, 1, 20, 20, 21, 32'h55, 0, 1, 0);
        cyc("wr20_byp",  0, 1, 20, 32'h66, 0, 0, 21, 20, 0, 32'h66, 0, 0);
        cyc("rd20",      0, 0, 0, 0, 0, 0, 20, 20, 32'h66, 32'h66, 0, 0);

        // r3 = 9 pending, then reset with a concurrent write: reset wins.
        cyc("wr3",       0, 1, 3, 32'd9, 0, 0, 3, 3, 32'd9, 32'd9, 0, 0);
        cyc("iss3",      0, 0, 0, 0, 1, 3, 3, 3, 32'd9, 32'd9, 0, 0);
        cyc("pend3",     0, 0, 0, 0, 0, 0, 3, 3, 32'd9, 32'd9, 1, 1);
        cyc("rst_wr3",   1, 1, 3, 32'hFF, 1, 3, 3, 15, 32'hFF, 32'd7, 0, 0);
        cyc("rd3_rst",   0, 0, 0, 0, 0, 0, 3, 15, 0, 0, 0, 0);
        cyc("rd20_rst",  0, 0, 0, 0, 0, 0, 20, 5, 0, 0, 0, 0);

        // Let the monitor drain the last expectation, bounded.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
